// File: rtl/neuron_scheduler.sv
// Layer sequencer for the shared MAC/summation datapath: clear, stream addresses, sum, write back.
// Optional sum watchdog enabled by defining SCHED_TIMEOUT_EN.
module neuron_scheduler #(
  parameter int unsigned NEUR_W  = 4,
  parameter int unsigned INPUT_W = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [1:0]                  i_layer,
  input  logic [NEUR_W:0]             i_n_neurons,
  input  logic [INPUT_W:0]            i_n_inputs,
  input  logic                        i_sum_done,
  output logic [2+NEUR_W+INPUT_W-1:0] o_w_addr,
  output logic [2+INPUT_W-1:0]        o_x_addr,
  output logic                        o_mac_clr,
  output logic                        o_mac_en,
  output logic                        o_sum_trigger,
  output logic                        o_act_we,
  output logic [2+NEUR_W-1:0]         o_act_addr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  typedef enum logic [2:0] {
    StIdle, StClear, StMac, StFlush, StSum, StWaitSum, StWrite, StDone
  } state_e;

  state_e                      r_state;
  logic [1:0]                  r_layer;
  logic [NEUR_W:0]             r_n_neurons;
  logic [INPUT_W:0]            r_n_inputs;
  logic [NEUR_W-1:0]           r_neur_idx;
  logic [INPUT_W-1:0]          r_in_idx;
  logic [2+NEUR_W+INPUT_W-1:0] r_w_addr;
  logic [2+INPUT_W-1:0]        r_x_addr;
  logic [2+NEUR_W-1:0]         r_act_addr;
  logic                        r_mac_clr;
  logic                        r_mac_pipe;
  logic                        r_mac_en;
  logic                        r_sum_trigger;
  logic                        r_act_we;
  logic                        r_busy;
  logic                        r_done;
  logic                        w_last_in;
  logic                        w_last_neur;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] r_wd;
  logic           r_timeout;
  logic           r_err;
  assign o_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
  assign o_err = 1'b0;
`endif

  // Compare in the wider count domain so a full 2^W count never wraps the index.
  assign w_last_in   = ({1'b0, r_in_idx} == r_n_inputs - (INPUT_W+1)'(1));
  assign w_last_neur = ({1'b0, r_neur_idx} == r_n_neurons - (NEUR_W+1)'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_layer       <= '0;
      r_n_neurons   <= '0;
      r_n_inputs    <= '0;
      r_neur_idx    <= '0;
      r_in_idx      <= '0;
      r_w_addr      <= '0;
      r_x_addr      <= '0;
      r_act_addr    <= '0;
      r_mac_clr     <= 1'b0;
      r_mac_pipe    <= 1'b0;
      r_mac_en      <= 1'b0;
      r_sum_trigger <= 1'b0;
      r_act_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      r_wd          <= '0;
      r_timeout     <= 1'b0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_mac_clr     <= 1'b0;
      r_mac_pipe    <= 1'b0;
      r_mac_en      <= r_mac_pipe;  // RAM data arrives one cycle after its address
      r_sum_trigger <= 1'b0;
      r_act_we      <= 1'b0;
      r_done        <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_layer     <= i_layer;
            r_n_neurons <= i_n_neurons;
            r_n_inputs  <= i_n_inputs;
            r_neur_idx  <= '0;
            r_busy      <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
`endif
            r_state     <= (i_n_neurons == '0 || i_n_inputs == '0) ? StDone : StClear;
          end
        end
        StClear: begin
          r_mac_clr <= 1'b1;
          r_in_idx  <= '0;
          r_state   <= StMac;
        end
        StMac: begin
          r_w_addr   <= {r_layer, r_neur_idx, r_in_idx};
          r_x_addr   <= {r_layer, r_in_idx};
          r_mac_pipe <= 1'b1;
          if (w_last_in) begin
            r_state <= StFlush;
          end else begin
            r_in_idx <= r_in_idx + INPUT_W'(1);
          end
        end
        StFlush: r_state <= StSum;
        StSum: begin
          r_sum_trigger <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
          r_wd          <= '0;
`endif
          r_state       <= StWaitSum;
        end
        StWaitSum: begin
          if (i_sum_done) begin
            r_state <= StWrite;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (r_wd == WdW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_wd <= r_wd + WdW'(1);
          end
`endif
        end
        StWrite: begin
          r_act_we   <= 1'b1;
          r_act_addr <= {r_layer, r_neur_idx};
          if (w_last_neur) begin
            r_state <= StDone;
          end else begin
            r_neur_idx <= r_neur_idx + NEUR_W'(1);
            r_state    <= StClear;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
          r_err   <= r_timeout;
`endif
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_w_addr      = r_w_addr;
  assign o_x_addr      = r_x_addr;
  assign o_mac_clr     = r_mac_clr;
  assign o_mac_en      = r_mac_en;
  assign o_sum_trigger = r_sum_trigger;
  assign o_act_we      = r_act_we;
  assign o_act_addr    = r_act_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
